// File: rtl/ldpc_ber_frame_sequencer.sv
// LDPC BER self-test frame sequencer: LFSR message, exact-weight error mask, decode check.
// Optional decode timeout is enabled by defining LDPC_BER_TIMEOUT_EN.
module ldpc_ber_frame_sequencer #(
  parameter int MM     = 168,
  parameter int NN     = 208,
  parameter int LFSR_W = 32,
  parameter int CNT_W  = 32,
  parameter int TMO_W  = 16
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               cfg_run_i,
  input  logic               cfg_stop_i,
  input  logic [CNT_W-1:0]   cfg_frames_i,
  input  logic [8:0]         cfg_err_bits_i,
  input  logic [31:0]        cfg_seed_i,
  input  logic [TMO_W-1:0]   cfg_tmo_i,
  output logic [NN-MM-1:0]   msg_o,
  input  logic               enc_valid_i,
  input  logic [NN-1:0]      enc_cword_i,
  output logic [NN-1:0]      err_mask_o,
  output logic               start_dec_o,
  input  logic               dec_done_i,
  input  logic [NN-1:0]      dec_word_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [CNT_W-1:0]   frames_o,
  output logic [CNT_W-1:0]   fails_o,
  output logic [CNT_W-1:0]   bit_errs_o,
  output logic [CNT_W-1:0]   tmo_cnt_o
);

  localparam int K = NN - MM;
  localparam logic [8:0] K_LAST = 9'(K - 1);
  localparam logic [8:0] NN_9 = 9'(NN);
  localparam logic [LFSR_W-1:0] TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {
    S_IDLE, S_MSG, S_ENC_WAIT, S_ERR,
    S_START, S_DEC_WAIT, S_CHECK, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [K-1:0]      msg_q, msg_d;
  logic [NN-1:0]     mask_q, mask_d;
  logic [NN-1:0]     cword_q, cword_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]  frames_q, frames_d;
  logic [CNT_W-1:0]  fails_q, fails_d;
  logic [CNT_W-1:0]  bits_q, bits_d;
  logic              done_q, done_d;
  logic              start;

  logic [LFSR_W-1:0] lfsr_nx;
  logic [8:0]        ebits;
  logic [NN-1:0]     onehot;
  logic              hit;
  logic [8:0]        e_w;
  logic [CNT_W-1:0]  frames_inc;

  function automatic logic [8:0] popcnt(input logic [NN-1:0] v);
    logic [8:0] c;
    c = '0;
    for (int i = 0; i < NN; i++) c = c + {8'd0, v[i]};
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(
    input logic [CNT_W-1:0] a,
    input logic [CNT_W-1:0] b
  );
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

`ifdef LDPC_BER_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             to_q, to_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  assign tmo_cnt_o = tcnt_q;
`else
  logic unused_tmo;
  assign unused_tmo = ^cfg_tmo_i;
  assign tmo_cnt_o  = '0;
`endif

  assign lfsr_nx = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
  assign ebits   = (cfg_err_bits_i > NN_9) ? NN_9 : cfg_err_bits_i;
  // Out-of-range positions shift the one-hot off the top and never hit.
  assign onehot  = {{(NN-1){1'b0}}, 1'b1} << lfsr_q[7:0];
  assign hit     = |(onehot & ~mask_q);
  assign frames_inc = sat_add(frames_q, CNT_W'(1));

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    msg_d    = msg_q;
    mask_d   = mask_q;
    cword_d  = cword_q;
    cnt_d    = cnt_q;
    frames_d = frames_q;
    fails_d  = fails_q;
    bits_d   = bits_q;
    done_d   = done_q;
    start    = 1'b0;
    e_w      = popcnt(dec_word_i ^ cword_q);
`ifdef LDPC_BER_TIMEOUT_EN
    tmo_d    = tmo_q;
    to_d     = to_q;
    tcnt_d   = tcnt_q;
    if (to_q) e_w = NN_9;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (cfg_run_i) begin
          lfsr_d   = (cfg_seed_i == '0) ? 32'd1 : cfg_seed_i;
          frames_d = '0;
          fails_d  = '0;
          bits_d   = '0;
          done_d   = 1'b0;
          cnt_d    = '0;
`ifdef LDPC_BER_TIMEOUT_EN
          tcnt_d   = '0;
`endif
          state_d  = S_MSG;
        end
      end
      S_MSG: begin
        msg_d  = {msg_q[K-2:0], lfsr_q[0]};
        lfsr_d = lfsr_nx;
        cnt_d  = cnt_q + 9'd1;
        if (cnt_q == K_LAST) begin
          mask_d  = '0;
          cnt_d   = '0;
          state_d = S_ENC_WAIT;
        end
      end
      S_ENC_WAIT: begin
        // cnt_q marks that the mandatory first wait cycle has passed.
        if (cnt_q == '0) begin
          cnt_d = 9'd1;
        end else if (enc_valid_i) begin
          cword_d = enc_cword_i;
          cnt_d   = '0;
          state_d = (ebits == '0) ? S_START : S_ERR;
        end
      end
      S_ERR: begin
        lfsr_d = lfsr_nx;
        if (hit) begin
          mask_d = mask_q | onehot;
          cnt_d  = cnt_q + 9'd1;
          if (cnt_q + 9'd1 == ebits) state_d = S_START;
        end
      end
      S_START: begin
        start   = 1'b1;
        state_d = S_DEC_WAIT;
`ifdef LDPC_BER_TIMEOUT_EN
        tmo_d   = '0;
        to_d    = 1'b0;
`endif
      end
      S_DEC_WAIT: begin
        if (dec_done_i) begin
          state_d = S_CHECK;
        end
`ifdef LDPC_BER_TIMEOUT_EN
        else if (cfg_tmo_i != '0) begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_d == cfg_tmo_i) begin
            to_d    = 1'b1;
            state_d = S_CHECK;
          end
        end
`endif
      end
      S_CHECK: begin
        frames_d = frames_inc;
        bits_d   = sat_add(bits_q, CNT_W'(e_w));
        if (e_w != '0) fails_d = sat_add(fails_q, CNT_W'(1));
`ifdef LDPC_BER_TIMEOUT_EN
        if (to_q) tcnt_d = sat_add(tcnt_q, CNT_W'(1));
`endif
        cnt_d = '0;
        if (cfg_frames_i != '0 && frames_inc >= cfg_frames_i)
          state_d = S_DONE;
        else
          state_d = S_MSG;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort: drop the frame in flight, keep statistics untouched.
    if (state_q != S_IDLE && cfg_stop_i) begin
      state_d  = S_IDLE;
      start    = 1'b0;
      lfsr_d   = lfsr_q;
      msg_d    = msg_q;
      mask_d   = mask_q;
      cword_d  = cword_q;
      frames_d = frames_q;
      fails_d  = fails_q;
      bits_d   = bits_q;
      done_d   = done_q;
`ifdef LDPC_BER_TIMEOUT_EN
      tcnt_d   = tcnt_q;
`endif
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= S_IDLE;
      lfsr_q   <= 32'd1;
      msg_q    <= '0;
      mask_q   <= '0;
      cword_q  <= '0;
      cnt_q    <= '0;
      frames_q <= '0;
      fails_q  <= '0;
      bits_q   <= '0;
      done_q   <= 1'b0;
`ifdef LDPC_BER_TIMEOUT_EN
      tmo_q    <= '0;
      to_q     <= 1'b0;
      tcnt_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      msg_q    <= msg_d;
      mask_q   <= mask_d;
      cword_q  <= cword_d;
      cnt_q    <= cnt_d;
      frames_q <= frames_d;
      fails_q  <= fails_d;
      bits_q   <= bits_d;
      done_q   <= done_d;
`ifdef LDPC_BER_TIMEOUT_EN
      tmo_q    <= tmo_d;
      to_q     <= to_d;
      tcnt_q   <= tcnt_d;
`endif
    end
  end

  assign msg_o       = msg_q;
  assign err_mask_o  = mask_q;
  assign start_dec_o = start;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign frames_o    = frames_q;
  assign fails_o     = fails_q;
  assign bit_errs_o  = bits_q;

endmodule

// File: tb/tb_ldpc_ber_frame_sequencer.sv
// Bench for ldpc_ber_frame_sequencer: encoder/decoder models plus a frame-level reference model.
// Define LDPC_BER_TIMEOUT_EN to also exercise the decode timeout.
module tb_ldpc_ber_frame_sequencer;

  localparam int NN = 208;
  localparam int K  = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          run = 1'b0;
  logic          stop = 1'b0;
  logic [31:0]   frames_cfg = '0;
  logic [8:0]    err_cfg = '0;
  logic [31:0]   seed_cfg = '0;
  logic [15:0]   tmo_cfg = '0;
  logic [K-1:0]  msg;
  logic          enc_valid = 1'b0;
  logic [NN-1:0] enc_cword = '0;
  logic [NN-1:0] err_mask;
  logic          start_dec;
  logic          dec_done = 1'b0;
  logic [NN-1:0] dec_word = '0;
  logic          busy, done;
  logic [31:0]   frames, fails, bit_errs, tmo_cnt;

  int n_checks = 0;
  int n_errors = 0;

  ldpc_ber_frame_sequencer dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cfg_run_i(run), .cfg_stop_i(stop),
    .cfg_frames_i(frames_cfg), .cfg_err_bits_i(err_cfg),
    .cfg_seed_i(seed_cfg), .cfg_tmo_i(tmo_cfg),
    .msg_o(msg), .enc_valid_i(enc_valid), .enc_cword_i(enc_cword),
    .err_mask_o(err_mask), .start_dec_o(start_dec),
    .dec_done_i(dec_done), .dec_word_i(dec_word),
    .busy_o(busy), .done_o(done),
    .frames_o(frames), .fails_o(fails),
    .bit_errs_o(bit_errs), .tmo_cnt_o(tmo_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [NN-1:0] enc_f(input logic [K-1:0] m);
    return {m, m, m, m, m, m[7:0]} ^ {26{8'hA5}};
  endfunction

  function automatic int pc(input logic [NN-1:0] v);
    int c = 0;
    for (int i = 0; i < NN; i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic logic [31:0] lstep(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // Encoder: valid once msg has been stable for 2 cycles.
  logic [K-1:0] last_msg = '0;
  int stable = 0;
  always @(negedge clk) begin
    if (msg != last_msg) stable = 0;
    else if (stable < 10) stable++;
    last_msg  = msg;
    enc_valid = (stable >= 2);
    enc_cword = enc_f(msg);
  end

  // Decoder + start monitor. dmode: 0 clean, 1 all errors, 2 hang, 3 partial.
  int dmode = 0;
  int dcnt = 0;
  int width_err = 0;
  logic prev_start = 1'b0;
  logic [K-1:0]  obs_msg[$];
  logic [NN-1:0] obs_mask[$];
  logic [NN-1:0] obs_r[$];
  always @(negedge clk) begin
    logic [223:0] rw;
    if (rst) begin
      dcnt = 0;
      dec_done = 1'b0;
    end else if (dcnt > 0) begin
      dcnt--;
      dec_done = (dcnt == 0);
    end else begin
      dec_done = 1'b0;
    end
    if (start_dec && prev_start) width_err++;
    prev_start = start_dec;
    if (start_dec) begin
      rw = {$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom};
      obs_msg.push_back(msg);
      obs_mask.push_back(err_mask);
      obs_r.push_back(rw[NN-1:0]);
      case (dmode)
        1: dec_word = enc_cword ^ err_mask;
        3: dec_word = enc_cword ^ (err_mask & rw[NN-1:0]);
        default: dec_word = enc_cword;
      endcase
      if (dmode != 2) dcnt = 5;
    end
  end

  // Frame-level reference: message bits and exact-weight masks from the LFSR stream.
  logic [K-1:0]  exp_msg[$];
  logic [NN-1:0] exp_mask[$];
  task automatic build_model(input logic [31:0] seed, input int nf,
                             input int eb);
    logic [31:0] s;
    logic [K-1:0] m;
    logic [NN-1:0] mk;
    int ec, cnt, p;
    s = (seed == 0) ? 32'd1 : seed;
    ec = (eb > NN) ? NN : eb;
    exp_msg.delete();
    exp_mask.delete();
    for (int f = 0; f < nf; f++) begin
      m = '0;
      for (int k = 0; k < K; k++) begin
        m = {m[K-2:0], s[0]};
        s = lstep(s);
      end
      mk = '0;
      cnt = 0;
      for (int g = 0; g < 100000 && cnt < ec; g++) begin
        p = int'(s[7:0]);
        if (p < NN && !mk[p]) begin
          mk[p] = 1'b1;
          cnt++;
        end
        s = lstep(s);
      end
      exp_msg.push_back(m);
      exp_mask.push_back(mk);
    end
  endtask

  task automatic start_run(input logic [31:0] sd, input int nf, input int eb);
    @(negedge clk);
    seed_cfg   = sd;
    frames_cfg = nf;
    err_cfg    = 9'(eb);
    run        = 1'b1;
    @(negedge clk);
    run        = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (busy) begin
      n_errors++;
      $display("FAIL %s: busy_o=1 after %0d cycles, required 0", nm, budget);
    end
  endtask

  task automatic chk(input string nm, input longint act, input longint req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, done, start_dec} !== 3'b000 || msg !== '0 || err_mask !== '0
        || frames !== 0 || fails !== 0 || bit_errs !== 0 || tmo_cnt !== 0) begin
      n_errors++;
      $display("FAIL reset: busy=%b done=%b frames=%0d msg=%h, required all 0",
               busy, done, frames, msg);
    end
  endtask

  task automatic test_single;
    int base = obs_msg.size();
    dmode = 0;
    start_run(32'd1, 1, 0);
    wait_idle(5000, "single_idle");
    build_model(32'd1, 1, 0);
    chk("single_frames", frames, 1);
    chk("single_fails", fails, 0);
    chk("single_bits", bit_errs, 0);
    chk("single_done", done, 1);
    chk("single_starts", obs_msg.size() - base, 1);
    chk("single_width", width_err, 0);
    n_checks++;
    if (obs_msg.size() > base && obs_msg[base] !== exp_msg[0]) begin
      n_errors++;
      $display("FAIL single_msg: got %h, required %h", obs_msg[base], exp_msg[0]);
    end
    chk("single_tmo", tmo_cnt, 0);
  endtask

  task automatic test_errors;
    int base = obs_msg.size();
    dmode = 1;
    start_run(32'h1234_5678, 4, 3);
    wait_idle(10000, "errors_idle");
    build_model(32'h1234_5678, 4, 3);
    chk("errors_starts", obs_msg.size() - base, 4);
    for (int f = 0; f < 4 && base + f < obs_mask.size(); f++) begin
      chk("errors_popcount", pc(obs_mask[base + f]), 3);
      n_checks++;
      if (obs_mask[base + f] !== exp_mask[f] || obs_msg[base + f] !== exp_msg[f]) begin
        n_errors++;
        $display("FAIL errors_frame%0d: mask %h msg %h, required %h %h", f,
                 obs_mask[base + f], obs_msg[base + f], exp_mask[f], exp_msg[f]);
      end
    end
    chk("errors_frames", frames, 4);
    chk("errors_fails", fails, 4);
    chk("errors_bits", bit_errs, 12);
  endtask

  task automatic test_clip;
    int base = obs_mask.size();
    dmode = 0;
    start_run(32'hCAFE_0001, 1, 300);
    wait_idle(20000, "clip_idle");
    chk("clip_starts", obs_mask.size() - base, 1);
    if (obs_mask.size() > base) chk("clip_popcount", pc(obs_mask[base]), NN);
    chk("clip_fails", fails, 0);
  endtask

  task automatic test_random;
    for (int it = 0; it < 3; it++) begin
      int base = obs_msg.size();
      logic [31:0] sd = $urandom;
      int nf = $urandom_range(1, 3);
      int eb = $urandom_range(0, 12);
      int e_tot = 0, f_tot = 0, e;
      dmode = 3;
      start_run(sd, nf, eb);
      repeat (3) @(negedge clk);
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      wait_idle(10000, "random_idle");
      build_model(sd, nf, eb);
      chk("random_starts", obs_msg.size() - base, nf);
      for (int f = 0; f < nf && base + f < obs_msg.size(); f++) begin
        n_checks++;
        if (obs_mask[base + f] !== exp_mask[f] || obs_msg[base + f] !== exp_msg[f]) begin
          n_errors++;
          $display("FAIL random_frame%0d: mask %h msg %h, required %h %h", f,
                   obs_mask[base + f], obs_msg[base + f], exp_mask[f], exp_msg[f]);
        end
        e = pc(exp_mask[f] & obs_r[base + f]);
        e_tot += e;
        f_tot += (e != 0) ? 1 : 0;
      end
      chk("random_frames", frames, nf);
      chk("random_fails", fails, f_tot);
      chk("random_bits", bit_errs, e_tot);
      chk("random_done", done, 1);
    end
  endtask

  task automatic test_stop;
    int n = 0;
    dmode = 0;
    start_run(32'h0BAD_F00D, 0, 1);
    while (frames < 2 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("stop_reach2", frames, 2);
    repeat (5) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_frames", frames, 2);
    chk("stop_done", done, 0);
    start_run(32'd7, 1, 0);
    chk("stop_rerun_clear", frames, 0);
    wait_idle(5000, "stop_rerun_idle");
    chk("stop_rerun_frames", frames, 1);
  endtask

  task automatic test_midreset;
    int base, n = 0;
    dmode = 0;
    start_run(32'h55AA_1234, 0, 2);
    while (frames < 1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    base = obs_msg.size();
    n = 0;
    while (obs_msg.size() == base && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("midreset_started", obs_msg.size() - base, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, done, start_dec} !== 3'b000 || msg !== '0 || err_mask !== '0
        || frames !== 0 || fails !== 0 || bit_errs !== 0) begin
      n_errors++;
      $display("FAIL midreset: busy=%b frames=%0d msg=%h mask_pc=%0d, required all 0",
               busy, frames, msg, pc(err_mask));
    end
    rst = 1'b0;
    base = obs_msg.size();
    start_run(32'd0, 1, 0);
    wait_idle(5000, "seed0_idle");
    build_model(32'd1, 1, 0);
    n_checks++;
    if (obs_msg.size() <= base || obs_msg[base] !== exp_msg[0]) begin
      n_errors++;
      $display("FAIL seed0_msg: got %h, required %h",
               (obs_msg.size() > base) ? obs_msg[base] : '0, exp_msg[0]);
    end
  endtask

  task automatic test_timeout;
    dmode = 2;
`ifdef LDPC_BER_TIMEOUT_EN
    tmo_cfg = 16'd10;
    start_run(32'd3, 2, 0);
    wait_idle(5000, "tmo_idle");
    chk("tmo_count", tmo_cnt, 2);
    chk("tmo_fails", fails, 2);
    chk("tmo_bits", bit_errs, 2 * NN);
    chk("tmo_frames", frames, 2);
`else
    tmo_cfg = 16'd10;
    start_run(32'd3, 2, 0);
    repeat (200) @(negedge clk);
    chk("hang_busy", busy, 1);
    chk("hang_tmo", tmo_cnt, 0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("hang_stop", busy, 0);
`endif
    tmo_cfg = '0;
    dmode = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_errors();
    test_clip();
    test_random();
    test_stop();
    test_midreset();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
